// File: rtl/cond_pkg.sv
// Shared types and flag bit positions for the NZCV condition interface.
package cond_pkg;

  typedef enum logic [1:0] {ADD = 2'b00, SUB = 2'b01, AND = 2'b10, ORR = 2'b11} alu_ctrl_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef logic [3:0] nzcv_t;

endpackage

// File: rtl/nzcv_compute.sv
// Combinational N,Z,C,V generation for the execute-stage ALU operation.
module nzcv_compute
  import cond_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [1:0]       ALUControl,
  input  logic             ShiftCarry,
  input  logic             CurV,
  output logic [3:0]       nzcv
);

  alu_ctrl_e        op;
  logic             is_sub;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] logic_res;

  assign op     = alu_ctrl_e'(ALUControl);
  assign is_sub = (op == SUB);
  assign b_op   = is_sub ? ~SrcB : SrcB;
  // Carry-out lands in sum[WIDTH]; it never reaches the N bit.
  assign sum    = {1'b0, SrcA} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};

  always_comb begin
    logic_res = SrcA & SrcB;
    nzcv      = '0;
    case (op)
      ADD, SUB: begin
        nzcv[FLAG_N] = sum[WIDTH-1];
        nzcv[FLAG_Z] = (sum[WIDTH-1:0] == '0);
        nzcv[FLAG_C] = sum[WIDTH];
        nzcv[FLAG_V] = ~(SrcA[WIDTH-1] ^ SrcB[WIDTH-1] ^ is_sub) & (SrcA[WIDTH-1] ^ sum[WIDTH-1]);
      end
      default: begin
        logic_res    = (op == AND) ? (SrcA & SrcB) : (SrcA | SrcB);
        nzcv[FLAG_N] = logic_res[WIDTH-1];
        nzcv[FLAG_Z] = (logic_res == '0);
        nzcv[FLAG_C] = ShiftCarry;
        nzcv[FLAG_V] = CurV;
      end
    endcase
  end

endmodule

// File: rtl/nzcv_flag_register.sv
// Architectural NZCV flag register with split write enables, stall and a one-entry shadow.
// Optional macro FLAG_BYPASS_EN drives Flags straight from the next-state value.
module nzcv_flag_register
  import cond_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter logic [3:0]  RST_FLAGS = 4'b0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [1:0]       ALUControl,
  input  logic             ShiftCarry,
  input  logic [1:0]       FlagW,
  input  logic             CondEx,
  input  logic             Stall,
  input  logic             Save,
  input  logic             Restore,
  output logic [3:0]       Flags,
  output logic [3:0]       ShadowFlags,
  output logic [3:0]       FlagsNext
);

  nzcv_t flags_q, flags_d;
  nzcv_t shadow_q, shadow_d;
  nzcv_t alu_flags;

  nzcv_compute #(
    .WIDTH(WIDTH)
  ) u_compute (
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .ALUControl(ALUControl),
    .ShiftCarry(ShiftCarry),
    .CurV      (flags_q[FLAG_V]),
    .nzcv      (alu_flags)
  );

  always_comb begin
    flags_d  = flags_q;
    shadow_d = shadow_q;
    if (!rst_n) begin
      flags_d  = RST_FLAGS;
      shadow_d = RST_FLAGS;
    end else if (!Stall) begin
      if (Restore) begin
        flags_d = shadow_q;
      end else if (CondEx) begin
        if (FlagW[1]) begin
          flags_d[FLAG_N] = alu_flags[FLAG_N];
          flags_d[FLAG_Z] = alu_flags[FLAG_Z];
        end
        if (FlagW[0]) begin
          flags_d[FLAG_C] = alu_flags[FLAG_C];
          flags_d[FLAG_V] = alu_flags[FLAG_V];
        end
      end
      // Shadow captures the pre-edge flags, so Save+Restore swaps the two.
      if (Save) begin
        shadow_d = flags_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q  <= RST_FLAGS;
      shadow_q <= RST_FLAGS;
    end else begin
      flags_q  <= flags_d;
      shadow_q <= shadow_d;
    end
  end

  assign FlagsNext   = flags_d;
  assign ShadowFlags = shadow_q;

`ifdef FLAG_BYPASS_EN
  assign Flags = flags_d;
`else
  assign Flags = flags_q;
`endif

endmodule
